seg7_bcd_counter_mux: RTL and testbench
=======================================

Name: seg7_bcd_counter_mux

Overview:
- Parametrised multi-digit BCD up/down counter with a time-multiplexed 7-segment display driver for the board's 8-anode display.
- Generalises the two-digit fixed-rate counter: digit count, step rate and scan rate are parameters, and it adds count direction, parallel load, wrap/saturate mode and a terminal-count flag.
- Sits at top level between the board switches/buttons and the a_to_g/AN/DP pins.

Parameters:
- DIGITS, 8, number of active BCD digits (1..8); digit i drives AN[i].
- INCR_DIV, 50000000, clk cycles per count step (>=2).
- REFRESH_DIV, 6250, clk cycles per display-scan advance (>=2).
- WRAP, 1, 1 = wrap at the terminal count, 0 = saturate (hold) at the terminal count.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; prescaler and counting freeze when low.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD load value; digit i = bits [4i+3:4i].
- a_to_g  output  7  active-low segments, a = bit 6.
- AN  output  8  active-low anode enables.
- DP  output  1  decimal point, constant 1 (off).
- tc  output  1  one-cycle pulse on a step that wraps or saturates.

Behaviour:
- Reset (clr_n = 0, asynchronous): count = 0, prescaler = 0, scan counter = 0, select = 0, AN = 8'hFF, a_to_g = 7'h7F, tc = 0. DP is always 1.
- Prescaler: counts 0..INCR_DIV-1 only while en = 1. step = en && prescaler == INCR_DIV-1; the prescaler returns to 0 on that cycle. It holds its value while en = 0.
- Priority: load > step.
  - load = 1: count <= load_val, with any nibble > 9 clamped to 9. The prescaler resets to 0 and no step occurs that cycle, regardless of en.
- Step up: digit 0 +1. A digit at 9 becomes 0 and carries into the next digit. Ripple is combinational within the same cycle.
- Step down: digit 0 -1. A digit at 0 becomes 9 and borrows from the next digit.
- Terminal count: all 9s when counting up, all 0s when counting down.
  - WRAP = 1: count wraps to all 0s (up) or all 9s (down).
  - WRAP = 0: count holds.
  - In both modes tc = 1 for exactly that cycle.
- Direction change takes effect on the next step; no effect on the prescaler.
- Scan: the scan counter runs 0..REFRESH_DIV-1 continuously, independent of en and load. On reaching REFRESH_DIV-1 it returns to 0 and select advances, with select = DIGITS-1 going to 0.
- Display register: each cycle AN <= ~(1 << select), with bits >= DIGITS forced to 1, and a_to_g <= decode(count digit select). AN and a_to_g update in the same cycle, so there is no ghosting.
- Decode: 0-9 use the standard patterns (0 = 0000001 ... 9 = 0000100). Non-BCD nibbles are unreachable; decode them as blank (1111111).
- Latency:
  - count updates 1 cycle after step/load.
  - a_to_g/AN reflect a new count or select 1 cycle later.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: any digit i > 0 whose value is 0, with every higher digit also 0, displays blank (a_to_g = 1111111). Its AN bit stays asserted so scan timing is unchanged. Digit 0 always shows its value, so count 0 shows a single "0".
- Undefined: all DIGITS digits display, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK, and SEG_0..SEG_9 segment constants.
  - BCD_MAX = 4'd9.
  - A function/typedef for a 4-bit bcd_digit.
- One sub-module, seg7_decode: combinational 4-bit to 7-bit active-low decoder with a blank input.
- Counter, prescaler and scan logic remain in seg7_bcd_counter_mux.

Test Plan (INCR_DIV = 4, REFRESH_DIV = 3, DIGITS = 3 unless stated):
- Reset mid-count: drive clr_n low asynchronously between edges -> AN = FF, a_to_g = 7F and count = 000 immediately; after release with en = 1, up = 1, the first step comes 4 cycles later -> count 001.
- Carry ripple: load 099 with up = 1 and en = 1 -> after 4 cycles count = 100, tc = 0. Load 999 -> next step gives 000 with a one-cycle tc pulse. With WRAP = 0 the same stimulus holds 999 and pulses tc.
- Borrow: load 100 with up = 0 -> next step gives 099. Load 000 -> WRAP = 1 gives 999 plus tc; WRAP = 0 holds 000 plus tc.
- Load priority and clamp: assert load and a step in the same cycle with load_val = 0xA5F -> count = 959, prescaler = 0, no tc.
- Scan: with en = 0, observe 9 cycles -> AN cycles FE, FD, FB every 3 cycles and AN[7:3] stay 1. a_to_g matches the selected digit on the same cycle as AN.
- SEG7_LEADING_ZERO_BLANK_EN defined, count = 005 -> digits 2 and 1 blank, digit 0 shows 0100100. Count = 000 -> digit 0 shows 0000001.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the BCD counter / 7-segment display slice.
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Active-low segments, a = bit 6 ... g = bit 0.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_digit_t  i_digit,
  input  logic        i_blank,
  output logic [6:0]  o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with multiplexed 7-segment display driver.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_bcd_counter_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int INCR_DIV    = 50000000,
  parameter int REFRESH_DIV = 6250,
  parameter bit WRAP        = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [6:0]            a_to_g,
  output logic [7:0]            AN,
  output logic                  DP,
  output logic                  tc
);

  localparam int PW = (INCR_DIV > 2) ? $clog2(INCR_DIV) : 1;
  localparam int SW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(INCR_DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(REFRESH_DIV - 1);
  localparam logic [2:0]    SEL_LAST = 3'(DIGITS - 1);
  localparam logic [7:0]    AN_OFF   = 8'(16'hFFFF << DIGITS);

  logic [4*DIGITS-1:0] r_count;
  logic [PW-1:0]       r_presc;
  logic [SW-1:0]       r_scan;
  logic [2:0]          r_sel;
  logic [7:0]          r_an;
  logic [6:0]          r_seg;
  logic                r_tc;

  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_ld;
  logic                w_cy;
  bcd_digit_t          w_d;
  bcd_digit_t          w_dig;
  logic                w_blank;
  logic [6:0]          w_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                w_hz;
`endif

  // Full ripple in one cycle; the final carry/borrow marks the terminal count.
  always_comb begin
    w_next = r_count;
    w_cy   = 1'b1;
    w_d    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = r_count[4*i +: 4];
      if (w_cy) begin
        if (up) begin
          w_cy = (w_d == BCD_MAX);
          w_next[4*i +: 4] = w_cy ? 4'd0 : w_d + 4'd1;
        end else begin
          w_cy = (w_d == 4'd0);
          w_next[4*i +: 4] = w_cy ? BCD_MAX : w_d - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_ld = '0;
    for (int i = 0; i < DIGITS; i++)
      w_ld[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
  end

  always_comb begin
    w_dig   = '0;
    w_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    w_hz    = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      w_hz = w_hz && (r_count[4*i +: 4] == 4'd0);
`endif
      if (r_sel == 3'(i)) begin
        w_dig = r_count[4*i +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        w_blank = w_hz && (i > 0);
`endif
      end
    end
  end

  seg7_decode u_dec (
    .i_digit (w_dig),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
      r_presc <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count <= w_ld;
        r_presc <= '0;
      end else if (en) begin
        if (r_presc == P_LAST) begin
          r_presc <= '0;
          r_tc    <= w_cy;
          if (WRAP || !w_cy)
            r_count <= w_next;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_scan <= '0;
      r_sel  <= '0;
      r_an   <= 8'hFF;
      r_seg  <= SEG_BLANK;
    end else begin
      if (r_scan == S_LAST) begin
        r_scan <= '0;
        r_sel  <= (r_sel == SEL_LAST) ? 3'd0 : r_sel + 3'd1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_an  <= ~(8'h01 << r_sel) | AN_OFF;
      r_seg <= w_seg;
    end
  end

  assign a_to_g = r_seg;
  assign AN     = r_an;
  assign DP     = 1'b1;
  assign tc     = r_tc;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Scoreboard bench: wrapping and saturating instances driven side by side.
module tb_seg7_bcd_counter_mux;

  logic        clk = 1'b0;
  logic        clr_n, en, up, load;
  logic [11:0] load_val;
  logic [6:0]  seg_w, seg_s;
  logic [7:0]  an_w, an_s;
  logic        dp_w, dp_s, tc_w, tc_s;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    string       nm;
    logic [11:0] cw;
    logic [11:0] cs;
    logic        tw;
    logic        ts;
    bit          disp;
    logic [7:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t sb[$];

  seg7_bcd_counter_mux #(
    .DIGITS(3), .INCR_DIV(4), .REFRESH_DIV(3), .WRAP(1'b1)
  ) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .a_to_g(seg_w), .AN(an_w), .DP(dp_w), .tc(tc_w)
  );

  seg7_bcd_counter_mux #(
    .DIGITS(3), .INCR_DIV(4), .REFRESH_DIV(3), .WRAP(1'b0)
  ) dut_s (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .a_to_g(seg_s), .AN(an_s), .DP(dp_s), .tc(tc_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] exp_seg(logic [11:0] v, int idx);
    logic [3:0] d;
    d = v[4*idx +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      bit bl = 1'b1;
      for (int j = idx; j < 3; j++)
        if (v[4*j +: 4] != 4'd0) bl = 1'b0;
      if (bl) return 7'b1111111;
    end
`endif
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(string nm, string f, logic [11:0] act, logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s @cyc %0d: got %h expected %h", nm, f, cyc, act, exp);
    end
  endtask

  task automatic push(int c, string nm, logic [11:0] cw, logic [11:0] cs,
                      logic tw, logic ts, bit disp, logic [7:0] an,
                      logic [6:0] seg);
    exp_t e;
    e.cyc = c; e.nm = nm; e.cw = cw; e.cs = cs; e.tw = tw; e.ts = ts;
    e.disp = disp; e.an = an; e.seg = seg;
    sb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops every entry whose cycle has arrived and compares it.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk(e.nm, "count_wrap", dut.r_count, e.cw);
      chk(e.nm, "count_sat", dut_s.r_count, e.cs);
      chk(e.nm, "tc_wrap", 12'(tc_w), 12'(e.tw));
      chk(e.nm, "tc_sat", 12'(tc_s), 12'(e.ts));
      chk(e.nm, "DP", 12'(dp_w), 12'd1);
      if (e.disp) begin
        chk(e.nm, "AN", 12'(an_w), 12'(e.an));
        chk(e.nm, "a_to_g", 12'(seg_w), 12'(e.seg));
        chk(e.nm, "AN_sat", 12'(an_s), 12'(e.an));
        chk(e.nm, "a_to_g_sat", 12'(seg_s), 12'(e.seg));
      end
    end
  end

  task automatic load_and_step(string nm, logic [11:0] val, logic upv,
                               logic [11:0] ld, logic [11:0] sw,
                               logic [11:0] ss, logic tw, logic ts);
    int b;
    b = cyc;
    up = upv; load = 1'b1; load_val = val;
    push(b + 1, {nm, "_load"}, ld, ld, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(1);
    load = 1'b0;
    push(b + 4, {nm, "_pre"}, ld, ld, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    push(b + 5, {nm, "_step"}, sw, ss, tw, ts, 1'b0, 8'hFF, 7'h7F);
    push(b + 6, {nm, "_post"}, sw, ss, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(5);
  endtask

  task automatic scan_check(string nm, logic [11:0] v);
    logic [7:0] prev;
    bit found;
    int c, idx;
    load = 1'b1; load_val = v;
    tick(1);
    load = 1'b0;
    push(cyc, {nm, "_load"}, v, v, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(2);
    prev = an_w;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an_w == 8'hFE && prev != 8'hFE) found = 1'b1;
      prev = an_w;
    end
    if (!found) begin
      n_chk++; n_err++;
      $display("FAIL %s_sync: got AN %h expected a FE phase within 20 cycles", nm, an_w);
    end else begin
      c = cyc;
      for (int k = 1; k <= 9; k++) begin
        idx = (k / 3) % 3;
        push(c + k, nm, v, v, 1'b0, 1'b0, 1'b1,
             ~(8'h01 << idx), exp_seg(v, idx));
      end
    end
    tick(11);
  endtask

  initial begin
    int b;
    clr_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    tick(2);
    push(cyc, "reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 8'hFF, 7'h7F);
    clr_n = 1'b1; en = 1'b1;
    b = cyc;
    push(b + 3, "first_pre", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    push(b + 4, "first_step", 12'h001, 12'h001, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(6);
    #2 clr_n = 1'b0;
    push(cyc, "async_reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 8'hFF, 7'h7F);
    tick(1);
    clr_n = 1'b1;
    b = cyc;
    push(b + 3, "rel_pre", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    push(b + 4, "rel_step", 12'h001, 12'h001, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(4);

    load_and_step("carry",   12'h099, 1'b1, 12'h099, 12'h100, 12'h100, 1'b0, 1'b0);
    load_and_step("wrap_up", 12'h999, 1'b1, 12'h999, 12'h000, 12'h999, 1'b1, 1'b1);
    load_and_step("borrow",  12'h100, 1'b0, 12'h100, 12'h099, 12'h099, 1'b0, 1'b0);
    load_and_step("wrap_dn", 12'h000, 1'b0, 12'h000, 12'h999, 12'h000, 1'b1, 1'b1);

    // Prescaler sits at its last value here, so load collides with a step.
    tick(2);
    up = 1'b1; load = 1'b1; load_val = 12'hA5F;
    push(cyc + 1, "ld_prio", 12'h959, 12'h959, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(1);
    load = 1'b0;
    b = cyc;
    push(b + 3, "ld_prio_pre", 12'h959, 12'h959, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    push(b + 4, "ld_prio_step", 12'h960, 12'h960, 1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F);
    tick(4);

    en = 1'b0;
    scan_check("scan123", 12'h123);
    scan_check("scan005", 12'h005);
    scan_check("scan000", 12'h000);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_chk++; n_err++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
